load_aligner: RTL and testbench

Load-path counterpart of the store data shifter in the memory stage. The block captures a load request's byte offset and load type, then waits for the data-memory read word. It extracts, sign/zero-extends or merges the addressed bytes into a register-ready 32-bit value, and holds that value under a valid/ready handshake until the writeback stage accepts it. Memory is little-endian, and the byte-lane conventions match the store side exactly.

---
 rtl/load_aligner.sv | 128 ++++++++++++
 tb/tb_load_aligner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_aligner.sv
// Load-path byte aligner: extracts, extends or merges a loaded word for writeback.
// Optional misalignment flagging is enabled by LOAD_ALIGNER_MISALIGN_CHECK_EN.
module load_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic [2:0]  load_sel,
  input  logic        load_unsigned,
  input  logic [31:0] rt_data,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t      state, state_nx;
  logic        take_req, take_rsp;
  logic [1:0]  addr_q;
  logic [2:0]  sel_q;
  logic        uns_q;
  logic [31:0] rt_q;
  logic [31:0] data_q, res;
  logic        err_q, err;

  logic        is_byte, is_half, is_word, is_lwr, is_lwl;
  logic [4:0]  sh_r, sh_l;
  logic [31:0] m_sr, m_sl;
  logic [7:0]  b_val;
  logic [15:0] h_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      sel_q  <= '0;
      uns_q  <= 1'b0;
      rt_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (take_req) begin
        addr_q <= req_addr;
        sel_q  <= load_sel;
        uns_q  <= load_unsigned;
        rt_q   <= rt_data;
      end
      if (take_rsp) begin
        data_q <= res;
        err_q  <= err;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    take_req  = 1'b0;
    take_rsp  = 1'b0;
    req_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          take_req = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          take_rsp = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // 3-k for a 2-bit k is simply ~k
  assign sh_r  = {addr_q, 3'b000};
  assign sh_l  = {~addr_q, 3'b000};
  assign m_sr  = mem_rdata >> sh_r;
  assign m_sl  = mem_rdata << sh_l;
  assign b_val = m_sr[7:0];
  assign h_val = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  assign is_byte = (sel_q == 3'd0);
  assign is_half = (sel_q == 3'd1);
  assign is_word = (sel_q == 3'd2);
  assign is_lwr  = (sel_q == 3'd3);
  assign is_lwl  = sel_q[2];

  always_comb begin
    res = '0;
    unique case (1'b1)
      is_byte: res = {{24{b_val[7] & ~uns_q}}, b_val};
      is_half: res = {{16{h_val[15] & ~uns_q}}, h_val};
      is_word: res = mem_rdata;
      is_lwr:  res = m_sr | (rt_q & ~(32'hFFFF_FFFF >> sh_r));
      is_lwl:  res = m_sl | (rt_q & ~(32'hFFFF_FFFF << sh_l));
      default: res = '0;
    endcase
`ifdef LOAD_ALIGNER_MISALIGN_CHECK_EN
    err = (is_half & addr_q[0]) | (is_word & (|addr_q));
    if (err) res = '0;
`else
    err = 1'b0;
`endif
  end

  assign out_data = data_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_load_aligner.sv
// Scoreboard bench for load_aligner: expected results queued at request,
// compared when the writeback handshake completes.
module tb_load_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [2:0]  load_sel;
  logic        load_unsigned;
  logic [31:0] rt_data;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  load_aligner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .load_sel     (load_sel),
    .load_unsigned(load_unsigned),
    .rt_data      (rt_data),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] a, input logic [2:0] s,
                                 input logic u, input logic [31:0] rt,
                                 input logic [31:0] m);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    int          k;
    k = int'(a);
    e.err = 1'b0;
    case (a)
      2'd0: b = m[7:0];
      2'd1: b = m[15:8];
      2'd2: b = m[23:16];
      default: b = m[31:24];
    endcase
    h = a[1] ? m[31:16] : m[15:0];
    if (s == 3'd0)
      e.data = u ? {24'h0, b} : {{24{b[7]}}, b};
    else if (s == 3'd1)
      e.data = u ? {16'h0, h} : {{16{h[15]}}, h};
    else if (s == 3'd2)
      e.data = m;
    else if (s == 3'd3)
      e.data = (m >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
    else
      e.data = (m << (8 * (3 - k))) | (rt & ~(32'hFFFF_FFFF << (8 * (3 - k))));
`ifdef LOAD_ALIGNER_MISALIGN_CHECK_EN
    if ((s == 3'd1 && a[0]) || (s == 3'd2 && a != 2'd0)) begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", out_data, e.data);
        check("err", {31'h0, addr_err}, {31'h0, e.err});
      end
    end
  end

  task automatic do_load(input logic [1:0] a, input logic [2:0] s,
                         input logic u, input logic [31:0] rt,
                         input logic [31:0] m, input int stall);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_ready_idle", {31'h0, req_ready}, 32'd1);
    e = model(a, s, u, rt, m);
    sb.push_back(e);
    req_valid     = 1'b1;
    req_addr      = a;
    load_sel      = s;
    load_unsigned = u;
    rt_data       = rt;
    mem_rvalid    = 1'b1;
    mem_rdata     = ~m;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    rt_data    = ~rt;
    req_addr   = ~a;
    check("req_ready_wait", {31'h0, req_ready}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = m;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < stall; i++) begin
      mem_rvalid = 1'b1;
      check("hold_valid", {31'h0, out_valid}, 32'd1);
      check("hold_req_ready", {31'h0, req_ready}, 32'd0);
      check("hold_data", out_data, e.data);
      @(posedge clk);
      #1;
    end
    mem_rvalid = 1'b0;
    check("out_valid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", {31'h0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_addr      = 2'd0;
    load_sel      = 3'd0;
    load_unsigned = 1'b0;
    rt_data       = 32'h0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_err", {31'h0, addr_err}, 32'd0);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    rst_n = 1'b1;

    do_load(2'd2, 3'd0, 1'b0, 32'h0, 32'h1285_3456, 0);
    do_load(2'd2, 3'd0, 1'b1, 32'h0, 32'h1285_3456, 0);
    do_load(2'd2, 3'd1, 1'b0, 32'h0, 32'h8001_7FFF, 0);
    do_load(2'd0, 3'd1, 1'b1, 32'h0, 32'h8001_7FFF, 0);
    do_load(2'd1, 3'd3, 1'b0, 32'h1122_3344, 32'hAABB_CCDD, 0);
    do_load(2'd1, 3'd4, 1'b0, 32'h1122_3344, 32'hAABB_CCDD, 0);
    do_load(2'd0, 3'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 5);
    do_load(2'd3, 3'd0, 1'b0, 32'h0, 32'h8012_3456, 0);
    do_load(2'd3, 3'd2, 1'b0, 32'h0, 32'h8765_4321, 0);
    do_load(2'd1, 3'd1, 1'b0, 32'h0, 32'h1234_8765, 0);
    do_load(2'd0, 3'd3, 1'b0, 32'h5566_7788, 32'h99AA_BBCC, 0);
    do_load(2'd3, 3'd3, 1'b0, 32'h5566_7788, 32'h99AA_BBCC, 0);
    do_load(2'd0, 3'd7, 1'b0, 32'h5566_7788, 32'h99AA_BBCC, 2);
    do_load(2'd3, 3'd5, 1'b0, 32'h5566_7788, 32'h99AA_BBCC, 0);
    for (int i = 0; i < 16; i++)
      do_load(2'($urandom_range(3)), 3'($urandom_range(7)),
              1'($urandom_range(1)), $urandom, $urandom,
              int'($urandom_range(2)));

    // reset in WAIT coinciding with a read response
    req_valid = 1'b1;
    req_addr  = 2'd0;
    load_sel  = 3'd2;
    rt_data   = 32'h0;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    rst_n      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    mem_rvalid = 1'b0;
    check("abort_ready", {31'h0, req_ready}, 32'd1);
    check("abort_data", out_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("abort_valid", {31'h0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
    end

    do_load(2'd3, 3'd2, 1'b0, 32'h0, 32'h0F0F_0F0F, 0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
